mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one unified memory port between the fetch stage (I-side, read-only) and the memory_access stage (D-side, read/write).
// - Arbitrates between the two sides and allows one outstanding transaction at a time.
// - Forwards each response to the side that owns it.
// - Drops in-flight fetch responses on a branch-mispredict flush.
// - Keeps grant and conflict performance counters.
// PARAMETERS
// ADDR_W      32  address width
// DATA_W      32  data width; wstrb width = DATA_W/8
// STARVE_MAX  4   consecutive lost I-side arbitrations before I-side is forced to win
// CNT_W       32  performance-counter width
// PORTS
// clk           in   1         clock; one clock domain
// rst           in   1         reset: asynchronous, active-low
// i_req         in   1         fetch request
// i_addr        in   ADDR_W    fetch address
// i_gnt         out  1         fetch request accepted this cycle
// i_rvalid      out  1         fetch data valid this cycle
// i_rdata       out  DATA_W    fetch data
// d_req         in   1         data request
// d_we          in   1         1 = write, 0 = read
// d_wstrb       in   DATA_W/8  byte write strobes
// d_addr        in   ADDR_W    data address
// d_wdata       in   DATA_W    write data
// d_gnt         out  1         data request accepted this cycle
// d_rvalid      out  1         read data / write ack valid
// d_rdata       out  DATA_W    read data
// flush         in   1         fetch-side redirect (mispredict); cancels the pending I response
// mem_req       out  1         memory request
// mem_we        out  1         memory write enable
// mem_wstrb     out  DATA_W/8  memory byte strobes
// mem_addr      out  ADDR_W    memory address
// mem_wdata     out  DATA_W    memory write data
// mem_ready     in   1         memory accepts the request this cycle
// mem_rvalid    in   1         memory response (read data or write ack)
// mem_rdata     in   DATA_W    memory read data
// cnt_i_gnt     out  CNT_W     I-side grants since reset
// cnt_d_gnt     out  CNT_W     D-side grants since reset
// cnt_conflict  out  CNT_W     cycles in IDLE with i_req & d_req both high
// err_spurious  out  1         sticky flag: mem_rvalid arrived in IDLE
// BEHAVIOUR
// - Reset (rst low, asynchronous):
//   - state = IDLE; starve_cnt, drop, all counters and err_spurious = 0.
//   - All gnt/rvalid/mem_* outputs = 0.
//   - An outstanding transaction is abandoned; the memory is reset by the same rst.
// - States: IDLE, WAIT_I, WAIT_D.
// - IDLE:
//   - mem_req = i_req | d_req.
//   - Winner = D if d_req, unless (i_req && starve_cnt == STARVE_MAX), in which case winner = I.
//   - mem_we/wstrb/addr/wdata are driven combinationally from the winner; for I: we = 0, wstrb = 0.
//   - Grant: winner's gnt = mem_req & mem_ready, in the same cycle.
//   - On an I grant go to WAIT_I; on a D grant go to WAIT_D. No grant: stay in IDLE.
// - WAIT_I / WAIT_D:
//   - mem_req = 0. Requests on either side are held off (gnt = 0).
//   - On mem_rvalid: pass mem_rdata through combinationally to the owner's rdata and pulse its rvalid the same cycle.
//   - Then return to IDLE. Latency from grant to rvalid is memory latency + 0.
//   - At least one IDLE cycle separates consecutive grants.
// - rdata outputs are 0 whenever the matching rvalid is 0.
// - flush:
//   - Sets drop if it is high in WAIT_I, or in the cycle of an I grant.
//   - In WAIT_I with drop (or flush high in the same cycle), mem_rvalid is consumed: i_rvalid stays 0 and state returns to IDLE.
//   - drop is cleared on that return.
//   - flush has no effect in IDLE without an I grant, or in WAIT_D.
// - starve_cnt (width $clog2(STARVE_MAX+1)):
//   - +1 for each IDLE cycle with i_req high and no I grant; saturates at STARVE_MAX.
//   - Cleared on an I grant, or whenever i_req = 0 in IDLE.
//   - Holds its value in the WAIT states.
// - Counters:
//   - cnt_i_gnt +1 per I grant; cnt_d_gnt +1 per D grant.
//   - cnt_conflict +1 per IDLE cycle with i_req & d_req both high.
//   - All counters wrap modulo 2^CNT_W.
// - err_spurious: set when mem_rvalid is high in IDLE. The response is ignored and no rvalid pulses. Cleared only by reset.
// - mem_ready = 0: the request is held, registered state does not change, and the starve count still advances.
// TESTING
// - Only i_req, addr 0x100, mem_ready = 1, memory latency 2 -> i_gnt in cycle 0, i_rvalid in cycle 2 with rdata; cnt_i_gnt = 1.
// - i_req and d_req held high, always ready, 1-cycle memory -> grant order D,D,D,D,I,D...; cnt_conflict counts every IDLE cycle.
// - I granted, flush high 1 cycle later, mem_rvalid rdata = 0xDEADBEEF -> i_rvalid stays 0, state returns to IDLE, next grant proceeds normally.
// - D write, wstrb = 4'b0011, wdata = 0x12345678 -> mem_we = 1 and strobes match; d_rvalid on the ack; i_req is not granted while in WAIT_D.
// - rst pulled low in WAIT_D -> all outputs 0 immediately; after release, state is IDLE and counters are 0.
// - mem_rvalid injected in IDLE -> err_spurious = 1 and stays set; no rvalid pulse on either side.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory port between fetch (read-only) and data (read/write) sides,
// one transaction outstanding at a time, with flush-drop of fetch responses and perf counters.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  input  logic                flush,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [CNT_W-1:0]    cnt_i_gnt,
  output logic [CNT_W-1:0]    cnt_d_gnt,
  output logic [CNT_W-1:0]    cnt_conflict,
  output logic                err_spurious
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SC_W   = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

  state_t            state, state_nxt;
  logic [SC_W-1:0]   starve_cnt, starve_nxt;
  logic              drop, drop_nxt;
  logic              force_i, win_d, win_i, spurious, conflict;

  logic              i_gnt_c, d_gnt_c, i_rvalid_c, d_rvalid_c;
  logic [DATA_W-1:0] i_rdata_c, d_rdata_c, mem_wdata_c;
  logic              mem_req_c, mem_we_c;
  logic [STRB_W-1:0] mem_wstrb_c;
  logic [ADDR_W-1:0] mem_addr_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      drop         <= 1'b0;
      cnt_i_gnt    <= '0;
      cnt_d_gnt    <= '0;
      cnt_conflict <= '0;
      err_spurious <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      drop       <= drop_nxt;
      if (i_gnt_c)  cnt_i_gnt    <= cnt_i_gnt + CNT_W'(1);
      if (d_gnt_c)  cnt_d_gnt    <= cnt_d_gnt + CNT_W'(1);
      if (conflict) cnt_conflict <= cnt_conflict + CNT_W'(1);
      if (spurious) err_spurious <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    starve_nxt  = starve_cnt;
    drop_nxt    = drop;
    force_i     = i_req && (starve_cnt == SC_W'(STARVE_MAX));
    win_d       = d_req && !force_i;
    win_i       = i_req && !win_d;
    spurious    = 1'b0;
    conflict    = 1'b0;
    i_gnt_c     = 1'b0;
    d_gnt_c     = 1'b0;
    i_rvalid_c  = 1'b0;
    d_rvalid_c  = 1'b0;
    i_rdata_c   = '0;
    d_rdata_c   = '0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    mem_wstrb_c = '0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    unique case (state)
      IDLE: begin
        mem_req_c = i_req | d_req;
        if (win_d) begin
          mem_we_c    = d_we;
          mem_wstrb_c = d_wstrb;
          mem_addr_c  = d_addr;
          mem_wdata_c = d_wdata;
        end else if (win_i) begin
          mem_addr_c  = i_addr;
        end
        i_gnt_c  = win_i && mem_ready;
        d_gnt_c  = win_d && mem_ready;
        spurious = mem_rvalid;
        conflict = i_req && d_req;
        // A flush in the grant cycle already targets the response we are about to wait for.
        if (i_gnt_c) begin
          state_nxt  = WAIT_I;
          drop_nxt   = flush;
          starve_nxt = '0;
        end else begin
          if (d_gnt_c) state_nxt = WAIT_D;
          if (!i_req)
            starve_nxt = '0;
          else if (starve_cnt != SC_W'(STARVE_MAX))
            starve_nxt = starve_cnt + SC_W'(1);
        end
      end
      WAIT_I: begin
        if (mem_rvalid) begin
          if (!(drop || flush)) begin
            i_rvalid_c = 1'b1;
            i_rdata_c  = mem_rdata;
          end
          state_nxt = IDLE;
          drop_nxt  = 1'b0;
        end else if (flush) begin
          drop_nxt = 1'b1;
        end
      end
      WAIT_D: begin
        if (mem_rvalid) begin
          d_rvalid_c = 1'b1;
          d_rdata_c  = mem_rdata;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced low while reset is asserted, independent of the request inputs.
  assign i_gnt     = rst & i_gnt_c;
  assign d_gnt     = rst & d_gnt_c;
  assign i_rvalid  = rst & i_rvalid_c;
  assign d_rvalid  = rst & d_rvalid_c;
  assign i_rdata   = rst ? i_rdata_c : '0;
  assign d_rdata   = rst ? d_rdata_c : '0;
  assign mem_req   = rst & mem_req_c;
  assign mem_we    = rst & mem_we_c;
  assign mem_wstrb = rst ? mem_wstrb_c : '0;
  assign mem_addr  = rst ? mem_addr_c : '0;
  assign mem_wdata = rst ? mem_wdata_c : '0;

endmodule
